hd44780_ctrl: RTL and testbench
===============================

Name: hd44780_ctrl

Overview:
Parametrised HD44780 character-LCD controller, successor to the fixed 4-bit driver. It runs the full power-on initialisation by instruction, then accepts command/data bytes over a valid/ready handshake. It supports a 4-bit or 8-bit bus, configurable line count and font, and inserts a per-command busy delay derived from the clock frequency. It sits between application logic (string/cursor sequencers) and the LCD pins, on the divided system clock.

Parameters:
BUS_W, 4, LCD data bus width; legal values 4 or 8.
CLK_HZ, 250000, frequency of clk; all delays are derived from it.
LINES, 2, display lines (1 or 2); sets the N bit of function set.
FONT_5X10, 0, sets the F bit of function set (only meaningful when LINES=1).

Ports:
clk  input  1  controller clock
rst  input  1  asynchronous reset, active-low
in_valid  input  1  request to write in_data
in_ready  output  1  high only in IDLE; transfer occurs when in_valid && in_ready
in_rs  input  1  0 = instruction, 1 = data
in_data  input  8  byte to write
busy  output  1  equal to !in_ready
init_done  output  1  set when the init sequence completes; stays high until reset
e  output  1  LCD enable
rs  output  1  LCD register select
db  output  BUS_W  LCD data; in 4-bit mode maps to LCD D7..D4

Behaviour:
- Cycle conversion: cyc(us) = max(1, ceil(us*CLK_HZ/1e6)). Derived counts: E_CYC=cyc(0.5), GAP_CYC=cyc(1), T_PWR=cyc(40000), T_INIT1=cyc(4500), T_SHORT=cyc(50), T_MID=cyc(150), T_LONG=cyc(2000).
- Reset (rst=0, async): e=0, rs=0, db=0, in_ready=0, busy=1, init_done=0. The FSM returns to PWR_WAIT and all counters clear. Reset mid-pulse or mid-init drops e immediately, and the full sequence reruns after release.
- Write engine (one transfer unit = one nibble in 4-bit mode, one byte in 8-bit mode):
  - SETUP: 1 cycle; rs/db driven, e=0.
  - PULSE: e=1 for E_CYC cycles.
  - HOLD: 1 cycle; e=0, rs/db unchanged.
  - 4-bit mode: high nibble first. After the high nibble's HOLD, go to GAP for GAP_CYC cycles, then SETUP for the low nibble.
  - WAIT: after the final HOLD, count the unit's delay. Exit returns to the calling state.
- Init sequence (rs=0 throughout, fixed order):
  - PWR_WAIT T_PWR.
  - Nibble/byte 0x3 (8-bit: 0x30), wait T_INIT1.
  - 0x3, wait T_MID.
  - 0x3, wait T_MID.
  - 4-bit only: single nibble 0x2, wait T_MID.
  - Function set 0x20 | DL<<4 | N<<3 | F<<2 (DL=1 iff BUS_W=8), wait T_SHORT.
  - 0x08 (display off), wait T_SHORT.
  - 0x01 (clear), wait T_LONG.
  - 0x06 (entry increment), wait T_SHORT.
  - 0x0C (display on, cursor off), wait T_SHORT.
  - Then set init_done and enter IDLE.
  - Single-nibble init writes in 4-bit mode skip the low-nibble phase.
- IDLE: in_ready=1. On handshake, latch in_rs/in_data and drop in_ready the next cycle.
- Post-write delay: T_LONG if in_rs=0 and in_data ∈ {0x01,0x02,0x03}; otherwise T_SHORT. in_ready returns to 1 on the cycle after WAIT expires.
- in_valid asserted while in_ready=0 is ignored; nothing is queued. Back-to-back requests are accepted on the first ready cycle.
- db bits not driven by the current unit are 0 whenever e=0 outside SETUP/PULSE/HOLD.
- The controller never reads busy-flag; R/W is not provided (tied low externally).

Decomposition:
- Package hd44780_pkg holds:
  - instruction constants: CLR=0x01, HOME=0x02, ENTRY=0x04, DISP=0x08, FSET=0x20
  - FSM state enum: PWR_WAIT, INIT_SEQ, IDLE, SETUP, PULSE, HOLD, GAP, WAIT
  - the cyc() constant function
- One sub-module hd44780_timer: loadable down-counter (load, value, done), sized by clog2(T_PWR+1). It is shared by all delays.
- Init steps come from a small case-indexed ROM inside hd44780_ctrl.

Test Plan:
1. BUS_W=4, CLK_HZ=250000, release rst:
   - No e rise for 10000 cycles.
   - Pulses db=3, 3, 3, 2, then nibble pairs 2/8, 0/8, 0/1, 0/6, 0/C.
   - Gaps ≥1125, 38, 38, 38 after the single nibbles; ≥500 cycles after 0/1.
   - Then init_done=1, in_ready=1.
2. Data 0x61 with in_rs=1 in IDLE:
   - Two pulses, db=6 then db=1, with rs=1 stable from SETUP through HOLD.
   - in_ready low until 13 cycles after the last HOLD.
3. Instruction 0x01:
   - in_ready stays low ≥500 cycles after the final HOLD.
   - Instruction 0x80 takes 13 cycles.
4. BUS_W=8, LINES=1:
   - Init bytes 0x30 ×3 (no 0x20 step), then 0x30, 0x08, 0x01, 0x06, 0x0C.
   - One pulse per byte.
5. in_valid held high from reset:
   - No accept before init_done.
   - Exactly one accept per ready window.
   - Two queued requests take 2×(transfer+13) cycles.
6. rst pulled low during PULSE of a data write:
   - e, rs, db = 0 in the same cycle; init_done=0.
   - After release, a fresh 10000-cycle wait and full init.

Source files
------------

// File: rtl/hd44780_pkg.sv
// hd44780_pkg: shared instruction codes, FSM/delay enums and the
// microsecond-to-cycle conversion used by the HD44780 controller.
package hd44780_pkg;

    localparam logic [7:0] CLR   = 8'h01;
    localparam logic [7:0] HOME  = 8'h02;
    localparam logic [7:0] ENTRY = 8'h04;
    localparam logic [7:0] DISP  = 8'h08;
    localparam logic [7:0] FSET  = 8'h20;

    typedef enum logic [2:0] {
        PWR_WAIT,
        INIT_SEQ,
        IDLE,
        SETUP,
        PULSE,
        HOLD,
        GAP,
        WAIT
    } state_t;

    typedef enum logic [1:0] {
        DLY_SHORT,
        DLY_MID,
        DLY_INIT1,
        DLY_LONG
    } dly_t;

    // Duration is given in nanoseconds so sub-microsecond timings stay integer.
    // Result is ceil(ns * clk_hz / 1e9), never less than one cycle.
    function automatic int cyc(input longint ns, input longint clk_hz);
        longint c;
        c = (ns * clk_hz + 999_999_999) / 1_000_000_000;
        return (c < 1) ? 1 : int'(c);
    endfunction

endpackage

// File: rtl/hd44780_timer.sv
// hd44780_timer: loadable down-counter shared by every delay in the
// controller. done is high while the count sits at zero.
module hd44780_timer #(
    parameter int W = 14
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] value,
    output logic         done
);

    logic [W-1:0] count;

    // Load takes priority; otherwise count down and park at zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (load) begin
            count <= value;
        end else if (count != '0) begin
            count <= count - W'(1);
        end
    end

    assign done = (count == '0);

endmodule

// File: rtl/hd44780_ctrl.sv
// hd44780_ctrl: HD44780 character-LCD controller. Runs the power-on
// initialisation by instruction, then writes command/data bytes accepted
// over a valid/ready handshake, with every delay derived from CLK_HZ.
module hd44780_ctrl
    import hd44780_pkg::*;
#(
    parameter int BUS_W     = 4,
    parameter int CLK_HZ    = 250000,
    parameter int LINES     = 2,
    parameter int FONT_5X10 = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_rs,
    input  logic [7:0]       in_data,
    output logic             busy,
    output logic             init_done,
    output logic             e,
    output logic             rs,
    output logic [BUS_W-1:0] db
);

    localparam int E_CYC   = cyc(500, CLK_HZ);
    localparam int GAP_CYC = cyc(1000, CLK_HZ);
    localparam int T_PWR   = cyc(40_000_000, CLK_HZ);
    localparam int T_INIT1 = cyc(4_500_000, CLK_HZ);
    localparam int T_SHORT = cyc(50_000, CLK_HZ);
    localparam int T_MID   = cyc(150_000, CLK_HZ);
    localparam int T_LONG  = cyc(2_000_000, CLK_HZ);
    localparam int TW      = $clog2(T_PWR + 1);

    localparam logic [3:0] LAST_STEP = 4'd8;
    localparam logic [7:0] FSET_BYTE = FSET
                                     | ((BUS_W == 8)     ? 8'h10 : 8'h00)
                                     | ((LINES == 2)     ? 8'h08 : 8'h00)
                                     | ((FONT_5X10 != 0) ? 8'h04 : 8'h00);

    state_t        state;
    logic [3:0]    step;
    logic          armed;
    logic          lo;
    logic          single;
    logic [7:0]    cur_byte;
    logic          cur_rs;
    dly_t          cur_dly;

    logic          tmr_load;
    logic [TW-1:0] tmr_value;
    logic          tmr_done;
    logic [TW-1:0] wait_val;

    logic [7:0]    rom_byte;
    logic          rom_single;
    dly_t          rom_dly;

    logic          need_gap;
    logic          long_cmd;

    // The bus unit for a byte: whole byte on an 8-bit bus, else one nibble.
    function automatic logic [BUS_W-1:0] unit_of(input logic [7:0] b, input logic low);
        if (BUS_W == 8) begin
            return BUS_W'(b);
        end else begin
            return BUS_W'(low ? b[3:0] : b[7:4]);
        end
    endfunction

    assign need_gap = (BUS_W == 4) && !lo && !single;
    assign long_cmd = !in_rs && ((in_data == CLR) || (in_data == HOME) || (in_data == 8'h03));
    assign busy     = ~in_ready;

    hd44780_timer #(
        .W(TW)
    ) u_timer (
        .clk  (clk),
        .rst  (rst),
        .load (tmr_load),
        .value(tmr_value),
        .done (tmr_done)
    );

    // Init ROM: byte, single-unit flag and post-write delay for each step.
    always_comb begin
        rom_byte   = FSET_BYTE;
        rom_single = 1'b0;
        rom_dly    = DLY_SHORT;
        case (step)
            4'd0: begin rom_byte = FSET | 8'h10; rom_single = 1'b1; rom_dly = DLY_INIT1; end
            4'd1: begin rom_byte = FSET | 8'h10; rom_single = 1'b1; rom_dly = DLY_MID;   end
            4'd2: begin rom_byte = FSET | 8'h10; rom_single = 1'b1; rom_dly = DLY_MID;   end
            4'd3: begin rom_byte = FSET;         rom_single = 1'b1; rom_dly = DLY_MID;   end
            4'd4: begin rom_byte = FSET_BYTE;                       rom_dly = DLY_SHORT; end
            4'd5: begin rom_byte = DISP;                            rom_dly = DLY_SHORT; end
            4'd6: begin rom_byte = CLR;                             rom_dly = DLY_LONG;  end
            4'd7: begin rom_byte = ENTRY | 8'h02;                   rom_dly = DLY_SHORT; end
            4'd8: begin rom_byte = DISP | 8'h04;                    rom_dly = DLY_SHORT; end
            default: ;
        endcase
    end

    // Translate the latched delay class into a timer preload (N cycles = N-1).
    always_comb begin
        case (cur_dly)
            DLY_MID:   wait_val = TW'(T_MID - 1);
            DLY_INIT1: wait_val = TW'(T_INIT1 - 1);
            DLY_LONG:  wait_val = TW'(T_LONG - 1);
            default:   wait_val = TW'(T_SHORT - 1);
        endcase
    end

    // Load the shared timer on entry to each timed state.
    always_comb begin
        tmr_load  = 1'b0;
        tmr_value = '0;
        case (state)
            PWR_WAIT: begin
                if (!armed) begin
                    tmr_load  = 1'b1;
                    tmr_value = TW'(T_PWR - 1);
                end
            end
            SETUP: begin
                tmr_load  = 1'b1;
                tmr_value = TW'(E_CYC - 1);
            end
            HOLD: begin
                tmr_load  = 1'b1;
                tmr_value = need_gap ? TW'(GAP_CYC - 1) : wait_val;
            end
            default: ;
        endcase
    end

    // Main FSM: init sequencing, handshake and write engine with registered pins.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= PWR_WAIT;
            step      <= '0;
            armed     <= 1'b0;
            lo        <= 1'b0;
            single    <= 1'b0;
            cur_byte  <= '0;
            cur_rs    <= 1'b0;
            cur_dly   <= DLY_SHORT;
            e         <= 1'b0;
            rs        <= 1'b0;
            db        <= '0;
            in_ready  <= 1'b0;
            init_done <= 1'b0;
        end else begin
            case (state)
                PWR_WAIT: begin
                    if (!armed) begin
                        armed <= 1'b1;
                    end else if (tmr_done) begin
                        state <= INIT_SEQ;
                    end
                end
                INIT_SEQ: begin
                    cur_byte <= rom_byte;
                    single   <= rom_single;
                    cur_dly  <= rom_dly;
                    cur_rs   <= 1'b0;
                    lo       <= 1'b0;
                    rs       <= 1'b0;
                    db       <= unit_of(rom_byte, 1'b0);
                    state    <= SETUP;
                end
                IDLE: begin
                    if (in_valid) begin
                        cur_byte <= in_data;
                        cur_rs   <= in_rs;
                        single   <= 1'b0;
                        lo       <= 1'b0;
                        cur_dly  <= long_cmd ? DLY_LONG : DLY_SHORT;
                        rs       <= in_rs;
                        db       <= unit_of(in_data, 1'b0);
                        in_ready <= 1'b0;
                        state    <= SETUP;
                    end
                end
                SETUP: begin
                    e     <= 1'b1;
                    state <= PULSE;
                end
                PULSE: begin
                    if (tmr_done) begin
                        e     <= 1'b0;
                        state <= HOLD;
                    end
                end
                HOLD: begin
                    db <= '0;
                    if (need_gap) begin
                        state <= GAP;
                    end else begin
                        rs    <= 1'b0;
                        state <= WAIT;
                    end
                end
                GAP: begin
                    if (tmr_done) begin
                        lo    <= 1'b1;
                        rs    <= cur_rs;
                        db    <= unit_of(cur_byte, 1'b1);
                        state <= SETUP;
                    end
                end
                WAIT: begin
                    if (tmr_done) begin
                        if (init_done) begin
                            in_ready <= 1'b1;
                            state    <= IDLE;
                        end else if (step == LAST_STEP) begin
                            init_done <= 1'b1;
                            in_ready  <= 1'b1;
                            state     <= IDLE;
                        end else begin
                            step  <= (BUS_W == 8 && step == 4'd2) ? 4'd4 : step + 4'd1;
                            state <= INIT_SEQ;
                        end
                    end
                end
                default: state <= PWR_WAIT;
            endcase
        end
    end

endmodule

// File: tb/tb_hd44780_ctrl.sv
// tb_hd44780_ctrl: self-checking bench for hd44780_ctrl. A 4-bit/2-line
// instance carries most of the checks; an 8-bit/1-line instance checks the
// byte-wide init order. Expected bus units go into scoreboard queues and are
// compared as each enable pulse appears.
module tb_hd44780_ctrl;

    typedef struct {
        logic       rs;
        logic [7:0] data;
        int         exp_wait;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc_n = 0;
    always @(posedge clk) cyc_n <= cyc_n + 1;

    logic       rst, in_valid, in_rs, in_ready, busy, init_done, e, rs;
    logic [7:0] in_data;
    logic [3:0] db;

    logic       rst8, in_valid8, in_rs8, in_ready8, busy8, init_done8, e8, rs8;
    logic [7:0] in_data8;
    logic [7:0] db8;

    int n_checks = 0;
    int n_errors = 0;

    logic [4:0] q[$];
    logic [8:0] q8[$];
    int         rises[$];
    int         acc_cycles[$];
    int         rises8 = 0;
    int         last_hold = 0;
    int         acc_early = 0;
    int         dbl = 0;
    bit         done8 = 0;

    // Expected minimum wait before each rise of the 4-bit init; 0 marks the
    // low nibble of a pair, which must follow its high nibble by exactly 4.
    int   gw[14] = '{0, 1125, 38, 38, 38, 0, 13, 0, 13, 0, 500, 0, 13, 0};
    vec_t vecs[8];

    hd44780_ctrl #(
        .BUS_W(4), .CLK_HZ(250000), .LINES(2), .FONT_5X10(0)
    ) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_rs(in_rs), .in_data(in_data), .busy(busy), .init_done(init_done),
        .e(e), .rs(rs), .db(db)
    );

    hd44780_ctrl #(
        .BUS_W(8), .CLK_HZ(250000), .LINES(1), .FONT_5X10(0)
    ) dut8 (
        .clk(clk), .rst(rst8), .in_valid(in_valid8), .in_ready(in_ready8),
        .in_rs(in_rs8), .in_data(in_data8), .busy(busy8), .init_done(init_done8),
        .e(e8), .rs(rs8), .db(db8)
    );

    task automatic check_output(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("[TB] FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        n_checks++;
        if (act < lo || act > hi) begin
            n_errors++;
            $display("[TB] FAIL %s: actual %0d required %0d..%0d", name, act, lo, hi);
        end
    endtask

    task automatic push_init4();
        logic [7:0] seq[5];
        seq = '{8'h28, 8'h08, 8'h01, 8'h06, 8'h0C};
        q.push_back(5'h03);
        q.push_back(5'h03);
        q.push_back(5'h03);
        q.push_back(5'h02);
        for (int i = 0; i < 5; i++) begin
            q.push_back({1'b0, seq[i][7:4]});
            q.push_back({1'b0, seq[i][3:0]});
        end
    endtask

    task automatic push_init8();
        logic [7:0] seq[8];
        seq = '{8'h30, 8'h30, 8'h30, 8'h30, 8'h08, 8'h01, 8'h06, 8'h0C};
        for (int i = 0; i < 8; i++) q8.push_back({1'b0, seq[i]});
    endtask

    task automatic wait_ready(input int budget);
        int n = 0;
        while (!in_ready && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        check_output("ready_wait", in_ready, 1);
    endtask

    task automatic wait_init(input int budget);
        int n = 0;
        while (!init_done && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        check_output("init_done_wait", init_done, 1);
    endtask

    task automatic apply_stimulus(input logic rs_v, input logic [7:0] d);
        wait_ready(2000);
        in_valid = 1'b1;
        in_rs    = rs_v;
        in_data  = d;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // 4-bit monitor: handshake pushes, pulse scoreboard, SETUP/HOLD stability.
    initial begin
        logic [4:0] u, exp_u, prev_u, cap_u;
        logic       prev_e, prev_acc;
        prev_e = 1'b0; prev_acc = 1'b0; prev_u = '0; cap_u = '0;
        forever begin
            @(negedge clk);
            u = {rs, db};
            if (!rst) begin
                prev_e = 1'b0; prev_acc = 1'b0; prev_u = u;
            end else begin
                if (in_valid && in_ready) begin
                    q.push_back({in_rs, in_data[7:4]});
                    q.push_back({in_rs, in_data[3:0]});
                    acc_cycles.push_back(cyc_n);
                    if (!init_done) acc_early++;
                    if (prev_acc) dbl++;
                    prev_acc = 1'b1;
                end else begin
                    prev_acc = 1'b0;
                end
                if (e && !prev_e) begin
                    rises.push_back(cyc_n);
                    check_output("setup_stable", u, prev_u);
                    if (q.size() == 0) begin
                        check_output("pulse_expected", 0, 1);
                    end else begin
                        exp_u = q.pop_front();
                        check_output("pulse_unit", u, exp_u);
                    end
                    cap_u = u;
                end
                if (!e && prev_e) begin
                    check_output("hold_stable", u, cap_u);
                    last_hold = cyc_n;
                end
                prev_e = e;
                prev_u = u;
            end
        end
    end

    // 8-bit monitor: one byte per pulse, compared against its own queue.
    initial begin
        logic prev_e8;
        logic [8:0] exp_b;
        prev_e8 = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst8) begin
                prev_e8 = 1'b0;
            end else begin
                if (e8 && !prev_e8) begin
                    rises8++;
                    if (q8.size() == 0) begin
                        check_output("pulse8_expected", 0, 1);
                    end else begin
                        exp_b = q8.pop_front();
                        check_output("pulse8_byte", {rs8, db8}, exp_b);
                    end
                end
                prev_e8 = e8;
            end
        end
    end

    // 8-bit instance: init order, then a single data byte in one pulse.
    initial begin
        int n;
        in_valid8 = 1'b0; in_rs8 = 1'b0; in_data8 = '0;
        n = 0;
        while (!init_done8 && n < 20000) begin
            @(posedge clk); #1;
            n++;
        end
        check_output("init8_done", init_done8, 1);
        check_output("init8_pulses", rises8, 8);
        check_output("init8_queue", q8.size(), 0);
        check_output("init8_ready", in_ready8, 1);
        q8.push_back({1'b1, 8'h41});
        in_valid8 = 1'b1; in_rs8 = 1'b1; in_data8 = 8'h41;
        @(posedge clk); #1;
        in_valid8 = 1'b0;
        n = 0;
        while (!in_ready8 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        check_output("data8_ready", in_ready8, 1);
        check_output("data8_pulses", rises8, 9);
        check_output("data8_queue", q8.size(), 0);
        done8 = 1;
    end

    // Main sequence: reset, 4-bit init, write table, reset mid-pulse with in_valid held.
    initial begin
        int rel, n;
        vecs[0] = '{1'b1, 8'h61, 13};
        vecs[1] = '{1'b0, 8'h01, 500};
        vecs[2] = '{1'b0, 8'h80, 13};
        vecs[3] = '{1'b0, 8'h02, 500};
        vecs[4] = '{1'b0, 8'h03, 500};
        vecs[5] = '{1'b0, 8'h04, 13};
        vecs[6] = '{1'b1, 8'h01, 13};
        vecs[7] = '{1'b0, 8'h00, 13};

        rst = 1'b0; rst8 = 1'b0;
        in_valid = 1'b0; in_rs = 1'b0; in_data = '0;
        repeat (3) @(posedge clk);
        #1;
        check_output("rst_e", e, 0);
        check_output("rst_rs", rs, 0);
        check_output("rst_db", db, 0);
        check_output("rst_ready", in_ready, 0);
        check_output("rst_busy", busy, 1);
        check_output("rst_init_done", init_done, 0);
        check_output("rst_e8", e8, 0);

        push_init4();
        push_init8();
        rel = cyc_n;
        rst = 1'b1; rst8 = 1'b1;
        wait_init(20000);
        check_output("init_ready", in_ready, 1);
        check_output("init_busy", busy, 0);
        check_output("init_pulses", rises.size(), 14);
        check_output("init_queue", q.size(), 0);
        check_output("init_last_wait", cyc_n - last_hold - 1, 13);
        if (rises.size() > 0) check_range("pwr_wait", rises[0] - rel, 10000, 10010);
        for (int i = 1; i < 14 && i < rises.size(); i++) begin
            if (gw[i] == 0) check_output("pair_gap", rises[i] - rises[i-1], 4);
            else            check_range("init_gap", rises[i] - rises[i-1], gw[i] + 3, gw[i] + 6);
        end

        for (int i = 0; i < 8; i++) begin
            apply_stimulus(vecs[i].rs, vecs[i].data);
            wait_ready(1000);
            check_output("post_wait", cyc_n - last_hold - 1, vecs[i].exp_wait);
            check_output("write_queue", q.size(), 0);
            check_output("write_busy", busy, 0);
        end

        apply_stimulus(1'b1, 8'h61);
        n = 0;
        while (!e && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check_output("pulse_seen", e, 1);
        rst = 1'b0;
        #1;
        check_output("midrst_e", e, 0);
        check_output("midrst_rs", rs, 0);
        check_output("midrst_db", db, 0);
        check_output("midrst_init_done", init_done, 0);
        check_output("midrst_busy", busy, 1);
        q.delete();
        rises.delete();
        acc_cycles.delete();
        acc_early = 0;
        dbl = 0;
        in_valid = 1'b1; in_rs = 1'b1; in_data = 8'h41;
        repeat (3) @(posedge clk);
        #1;
        push_init4();
        rel = cyc_n;
        rst = 1'b1;
        wait_init(20000);
        check_output("reinit_pulses", rises.size(), 14);
        if (rises.size() > 0) check_range("reinit_pwr_wait", rises[0] - rel, 10000, 10010);

        n = 0;
        while (acc_cycles.size() < 2 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        in_valid = 1'b0;
        check_output("held_accepts", acc_cycles.size(), 2);
        // One ready cycle + high/low nibble pair (7 cycles) + 13-cycle wait.
        if (acc_cycles.size() >= 2) check_output("accept_spacing", acc_cycles[1] - acc_cycles[0], 21);
        check_output("early_accepts", acc_early, 0);
        check_output("double_accepts", dbl, 0);
        wait_ready(200);
        check_output("held_queue", q.size(), 0);
        check_output("held_accepts_final", acc_cycles.size(), 2);

        n = 0;
        while (!done8 && n < 2000) begin
            @(posedge clk); #1;
            n++;
        end
        check_output("dut8_finished", done8, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
